// File: rtl/multiword_adder_ctrl.sv
// Wide add/subtract built from one N-bit ripple adder, one word per clock, LS word first.
// The carry between words is held in a register, so the critical path stays one word deep.

module adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         co
);
  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module multiword_adder_ctrl #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 ovf
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [IW-1:0]            idx;
  logic                     carry;
  logic [WORDS-1:0][N-1:0]  ra, rb, res;
  logic [N-1:0]             wa, wb, sum;
  logic                     co, last;

  assign wa   = ra[idx];
  assign wb   = rb[idx];
  assign last = (idx == IW'(WORDS - 1));

  adder #(.N(N)) u_adder (
    .a   (wa),
    .b   (wb),
    .cin (carry),
    .sum (sum),
    .co  (co)
  );

  // Subtraction is a + ~b + 1: invert b on capture and seed the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      res   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= sub ? ~b : b;
          carry <= sub;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          res[idx] <= sum;
          carry    <= co;
          if (last) begin
            cout  <= co;
            ovf   <= (ra[WORDS-1][N-1] == rb[WORDS-1][N-1]) && (sum[N-1] != ra[WORDS-1][N-1]);
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign result = res;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Randomised scoreboard bench: a 4-word instance plus a 1-word instance, each checked
// against plain-arithmetic expectations for result, carry, signed overflow, busy and done timing.
module tb_multiword_adder_ctrl;
  localparam int N = 8;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [31:0] result;

  logic        start1 = 1'b0, sub1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, cout1, ovf1;
  logic [7:0]  result1;

  int cyc = 0;
  int total = 0, passed = 0;

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ov;
    int          dcyc;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];

  multiword_adder_ctrl #(.N(N), .WORDS(WORDS)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  multiword_adder_ctrl #(.N(N), .WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Unsigned/signed arithmetic on w-bit values; done is due dc.
  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic s, input int w, input int dc);
    exp_t e;
    logic [63:0] m, x, y, r;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, ia} & m;
    y = {32'd0, ib} & m;
    if (!s) begin
      r    = x + y;
      e.co = r[w];
      r    = r & m;
      e.ov = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
    end else begin
      r    = (x - y) & m;
      e.co = (x >= y);
      e.ov = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
    end
    e.res  = r[31:0];
    e.dcyc = dc;
    return e;
  endfunction

  // Monitors: pop and compare on every done, and check busy against the pending op's window.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy", busy, (q.size() > 0 && cyc > q[0].dcyc - WORDS - 1 && cyc < q[0].dcyc));
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("result", result, e.res);
          chk("cout", cout, e.co);
          chk("ovf", ovf, e.ov);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy1", busy1, (q1.size() > 0 && cyc == q1[0].dcyc - 1));
      if (done1) begin
        if (q1.size() == 0) chk("spurious_done1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("done_cycle1", cyc, e.dcyc);
          chk("result1", result1, e.res);
          chk("cout1", cout1, e.co);
          chk("ovf1", ovf1, e.ov);
        end
      end
    end
  end

  // Called just after a falling edge; start is sampled on the next rising edge (cycle 0).
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is);
    a = ia; b = ib; sub = is; start = 1'b1;
    q.push_back(model(ia, ib, is, 32, cyc + WORDS + 1));
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
  endtask

  task automatic wait_done(input bit noise);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0) begin ok = 1; break; end
      if (noise) begin start = 1'($urandom); a = $urandom; b = $urandom; sub = 1'($urandom); end
    end
    start = 1'b0;
    if (!ok) begin chk("done_timeout", 0, 1); q.delete(); end
  endtask

  task automatic run1(input logic [7:0] ia, input logic [7:0] ib, input logic is);
    bit ok = 0;
    @(negedge clk);
    a1 = ia; b1 = ib; sub1 = is; start1 = 1'b1;
    q1.push_back(model({24'd0, ia}, {24'd0, ib}, is, 8, cyc + 2));
    @(negedge clk);
    start1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (q1.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin chk("done1_timeout", 0, 1); q1.delete(); end
  endtask

  logic [31:0] da [5] = '{32'hFFFFFFFF, 32'd5, 32'h12345678, 32'h7FFFFFFF, 32'h80000000};
  logic [31:0] db [5] = '{32'h00000001, 32'd7, 32'h12345678, 32'h00000001, 32'h00000001};
  logic        ds [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result1", result1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(da[i], db[i], ds[i]);
      wait_done(0);
    end

    // Start pulses in cycle 2 and in DONE must be ignored; next op accepted in cycle 6.
    @(negedge clk);
    issue(32'd1, 32'd2, 1'b0);
    @(negedge clk); start = 1'b1; a = 32'hFF; b = 32'hFF; sub = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 32'hFF;
    @(negedge clk);
    issue(32'hDEADBEEF, 32'h01234567, 1'b0);
    wait_done(0);

    // Reset in cycle 2 discards the operation and clears outputs immediately.
    @(negedge clk);
    issue(32'hAAAA5555, 32'h12121212, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    issue(32'd10, 32'd20, 1'b0);
    wait_done(0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      issue($urandom, (i % 8 == 0) ? 32'h80000000 : $urandom, 1'($urandom));
      wait_done(1);
    end

    run1(8'hFF, 8'h01, 1'b0);
    run1(8'h7F, 8'h01, 1'b0);
    run1(8'h03, 8'h05, 1'b1);
    for (int i = 0; i < 10; i++) run1(8'($urandom), 8'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
